// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the control-unit, instruction-memory and IF/ID
//               signals of the instruction-fetch stage.
//               master : the fetch unit (drives Imem_req/Imem_addr, Pc,
//                        IF/ID register outputs and Flush).
//               slave  : the surrounding pipeline / memory (drives Stall,
//                        Pcsrc, targets, Imem_ack, Imem_data).
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    logic        Stall;
    logic [1:0]  Pcsrc;
    logic [31:0] Br_target;
    logic [31:0] J_target;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_data;
    logic [31:0] Pc;
    logic [31:0] D_Inst;
    logic [31:0] D_Pc4;
    logic        D_Valid;
    logic        Flush;

    modport master (
        input  Stall, Pcsrc, Br_target, J_target, Imem_ack, Imem_data,
        output Imem_req, Imem_addr, Pc, D_Inst, D_Pc4, D_Valid, Flush
    );

    modport slave (
        output Stall, Pcsrc, Br_target, J_target, Imem_ack, Imem_data,
        input  Imem_req, Imem_addr, Pc, D_Inst, D_Pc4, D_Valid, Flush
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Holds the PC, requests instructions
//               from instruction memory and loads the IF/ID register. A
//               one-entry skid buffer captures a word that returns while the
//               pipeline is stalled so the memory cycle is not repeated.
// Ports       : Clk  - rising-edge clock
//               Rst  - synchronous active-high reset
//               bus  - fetch_unit_if.master (control inputs, imem request /
//                      response, Pc, IF/ID outputs, Flush)
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  wire logic       Clk,
    input  wire logic       Rst,
    fetch_unit_if.master    bus
);

    // FETCH: request outstanding, skid buffer empty.
    // HOLD : skid buffer holds a word captured during a stall, no request.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_sb_inst;
    logic [31:0] w_sb_inst_nxt;
    logic [31:0] r_d_inst;
    logic [31:0] w_d_inst_nxt;
    logic [31:0] r_d_pc4;
    logic [31:0] w_d_pc4_nxt;
    logic        r_d_valid;
    logic        w_d_valid_nxt;
    logic [31:0] w_pc_plus4;

    // 32-bit modulo add: 0xFFFF_FFFC + 4 wraps to 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_sb_inst <= '0;
            r_d_inst  <= NOP_INST;
            r_d_pc4   <= '0;
            r_d_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_sb_inst <= w_sb_inst_nxt;
            r_d_inst  <= w_d_inst_nxt;
            r_d_pc4   <= w_d_pc4_nxt;
            r_d_valid <= w_d_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_sb_inst_nxt = r_sb_inst;
        w_d_inst_nxt  = r_d_inst;
        w_d_pc4_nxt   = r_d_pc4;
        w_d_valid_nxt = r_d_valid;

        if (bus.Pcsrc[1]) begin
            // Redirect wins over stall; any word returning now belongs to
            // the wrong path and the skid contents are dropped as well.
            w_pc_nxt      = bus.Pcsrc[0] ? bus.J_target : bus.Br_target;
            w_d_inst_nxt  = NOP_INST;
            w_d_valid_nxt = 1'b0;
            w_sb_inst_nxt = '0;
            w_state_nxt   = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.Imem_ack) begin
                        if (!bus.Stall) begin
                            w_d_inst_nxt  = bus.Imem_data;
                            w_d_pc4_nxt   = w_pc_plus4;
                            w_d_valid_nxt = 1'b1;
                            w_pc_nxt      = w_pc_plus4;
                        end else begin
                            // Park the word; PC stays so D_Pc4 is computed
                            // from the right address on release.
                            w_sb_inst_nxt = bus.Imem_data;
                            w_state_nxt   = ST_HOLD;
                        end
                    end else if (!bus.Stall) begin
                        w_d_inst_nxt  = NOP_INST;
                        w_d_valid_nxt = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.Stall) begin
                        w_d_inst_nxt  = r_sb_inst;
                        w_d_pc4_nxt   = w_pc_plus4;
                        w_d_valid_nxt = 1'b1;
                        w_pc_nxt      = w_pc_plus4;
                        w_state_nxt   = ST_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    assign bus.Imem_req  = (r_state == ST_FETCH);
    assign bus.Imem_addr = r_pc;
    assign bus.Pc        = r_pc;
    assign bus.D_Inst    = r_d_inst;
    assign bus.D_Pc4     = r_d_pc4;
    assign bus.D_Valid   = r_d_valid;
    // Combinational so ID/EX can be squashed in the redirect cycle itself.
    assign bus.Flush     = bus.Pcsrc[1] & ~Rst;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A rule-level model of
//               the fetch stage is compared against the DUT on every falling
//               edge; directed sequences add literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        Clk;
    logic        Rst;
    logic        use_addr;   // memory returns its own address as data
    logic [31:0] tb_data;
    logic        chk_en;
    int          checks;
    int          errors;

    fetch_unit_if bus ();

    assign bus.Imem_data = use_addr ? bus.Imem_addr : tb_data;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model (rule table) ----------------
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_hold;
    logic [31:0] m_sb;

    always @(posedge Clk) begin
        if (Rst) begin
            m_pc    <= RESET_PC;
            m_inst  <= NOP_INST;
            m_pc4   <= 32'd0;
            m_valid <= 1'b0;
            m_hold  <= 1'b0;
        end else if (bus.Pcsrc == 2'b10 || bus.Pcsrc == 2'b11) begin
            m_pc    <= (bus.Pcsrc == 2'b11) ? bus.J_target : bus.Br_target;
            m_inst  <= NOP_INST;
            m_valid <= 1'b0;
            m_hold  <= 1'b0;
        end else if (m_hold) begin
            if (!bus.Stall) begin
                m_inst  <= m_sb;
                m_pc4   <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
                m_hold  <= 1'b0;
            end
        end else if (bus.Imem_ack && !bus.Stall) begin
            m_inst  <= bus.Imem_data;
            m_pc4   <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 32'd4;
        end else if (bus.Imem_ack) begin
            m_sb   <= bus.Imem_data;
            m_hold <= 1'b1;
        end else if (!bus.Stall) begin
            m_inst  <= NOP_INST;
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model_req",   {31'd0, bus.Imem_req}, {31'd0, ~m_hold});
            chk("model_addr",  bus.Imem_addr, m_pc);
            chk("model_pc",    bus.Pc, m_pc);
            chk("model_inst",  bus.D_Inst, m_inst);
            chk("model_pc4",   bus.D_Pc4, m_pc4);
            chk("model_valid", {31'd0, bus.D_Valid}, {31'd0, m_valid});
            chk("model_flush", {31'd0, bus.Flush}, {31'd0, bus.Pcsrc[1] & ~Rst});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic [1:0] src, input logic [31:0] br,
                         input logic [31:0] jt, input logic ack, input logic ua,
                         input logic [31:0] d);
        bus.Stall     = st;
        bus.Pcsrc     = src;
        bus.Br_target = br;
        bus.J_target  = jt;
        bus.Imem_ack  = ack;
        use_addr      = ua;
        tb_data       = d;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc(input logic st, input logic [1:0] src, input logic [31:0] br,
                       input logic [31:0] jt, input logic ack, input logic ua,
                       input logic [31:0] d);
        drive(st, src, br, jt, ack, ua, d);
        step();
    endtask

    logic [31:0] held_addr;

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        Rst    = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        Rst    = 1'b0;
        chk_en = 1'b1;

        // reset state
        chk("rst_pc",    bus.Pc, 32'h0);
        chk("rst_valid", {31'd0, bus.D_Valid}, 32'd0);
        chk("rst_req",   {31'd0, bus.Imem_req}, 32'd1);
        chk("rst_pc4",   bus.D_Pc4, 32'h0);

        // stream, data = address (Pcsrc=01 behaves as sequential)
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("s0_pc",    bus.Pc, 32'h4);
        chk("s0_inst",  bus.D_Inst, 32'h0);
        chk("s0_valid", {31'd0, bus.D_Valid}, 32'd1);
        chk("s0_pc4",   bus.D_Pc4, 32'h4);
        cyc(1'b0, 2'b01, 32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 1'b1, 32'd0);
        chk("s1_pc",   bus.Pc, 32'h8);
        chk("s1_inst", bus.D_Inst, 32'h4);

        // stall with ack at Pc=8
        cyc(1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'hAAAA_0008);
        chk("st_req",  {31'd0, bus.Imem_req}, 32'd0);
        chk("st_pc",   bus.Pc, 32'h8);
        chk("st_inst", bus.D_Inst, 32'h4);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1111_1111);
            chk("st_hold_req", {31'd0, bus.Imem_req}, 32'd0);
        end
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rel_inst", bus.D_Inst, 32'hAAAA_0008);
        chk("rel_pc4",  bus.D_Pc4, 32'hC);
        chk("rel_pc",   bus.Pc, 32'hC);
        chk("rel_req",  {31'd0, bus.Imem_req}, 32'd1);

        // branch redirect while in HOLD
        cyc(1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h5555_000C);
        chk("br_hold_req", {31'd0, bus.Imem_req}, 32'd0);
        drive(1'b1, 2'b10, 32'h40, 32'd0, 1'b1, 1'b0, 32'h0BAD_0BAD);
        #1;
        chk("br_flush", {31'd0, bus.Flush}, 32'd1);
        step();
        chk("br_pc",    bus.Pc, 32'h40);
        chk("br_valid", {31'd0, bus.D_Valid}, 32'd0);
        chk("br_inst",  bus.D_Inst, NOP_INST);
        chk("br_req",   {31'd0, bus.Imem_req}, 32'd1);
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("br_tgt_inst", bus.D_Inst, 32'h40);

        // jump with simultaneous ack
        cyc(1'b0, 2'b11, 32'd0, 32'h100, 1'b1, 1'b0, 32'h0000_DEAD);
        chk("j_pc",    bus.Pc, 32'h100);
        chk("j_valid", {31'd0, bus.D_Valid}, 32'd0);
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("j_inst", bus.D_Inst, 32'h100);
        chk("j_pc2",  bus.Pc, 32'h104);

        // slow memory: two wait cycles per fetch
        for (int k = 0; k < 3; k++) begin
            held_addr = 32'h104 + 32'(k * 4);
            for (int w = 0; w < 2; w++) begin
                cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
                chk("slow_addr",  bus.Imem_addr, held_addr);
                chk("slow_valid", {31'd0, bus.D_Valid}, 32'd0);
            end
            cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
            chk("slow_inst", bus.D_Inst, held_addr);
            chk("slow_pc",   bus.Pc, held_addr + 32'd4);
        end

        // unaligned target taken verbatim
        cyc(1'b0, 2'b10, 32'h203, 32'd0, 1'b1, 1'b0, 32'h77);
        chk("ua_pc", bus.Pc, 32'h203);
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("ua_inst", bus.D_Inst, 32'h203);
        chk("ua_pc4",  bus.D_Pc4, 32'h207);

        // wrap at top of address space
        cyc(1'b0, 2'b11, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        chk("w_pc", bus.Pc, 32'hFFFF_FFFC);
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("w_pc4",  bus.D_Pc4, 32'h0);
        chk("w_pc0",  bus.Pc, 32'h0);
        chk("w_inst", bus.D_Inst, 32'hFFFF_FFFC);

        // reset while in HOLD
        cyc(1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234_5678);
        chk("rh_req", {31'd0, bus.Imem_req}, 32'd0);
        Rst = 1'b1;
        cyc(1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234_5678);
        chk("rh_pc",    bus.Pc, RESET_PC);
        chk("rh_valid", {31'd0, bus.D_Valid}, 32'd0);
        chk("rh_req2",  {31'd0, bus.Imem_req}, 32'd1);
        Rst = 1'b0;
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("rh_inst", bus.D_Inst, 32'h0);
        chk("rh_pc2",  bus.Pc, 32'h4);

        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
